// File: rtl/sht10_meas_scheduler.sv
// Measurement cycle scheduler for the SHT10 engine: one temperature then one RH
// conversion per cycle, with timeout supervision, retry and a minimum cycle period.
module sht10_meas_scheduler #(
  parameter int unsigned PERIOD_CYC  = 100000000,
  parameter int unsigned TIMEOUT_CYC = 40000000,
  parameter int unsigned RECOV_CYC   = 20000,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        oneshot,
  input  logic        sns_busy,
  input  logic        sns_done,
  input  logic        sns_error,
  input  logic [13:0] sns_data,
  output logic        sns_start,
  output logic        sns_sel,
  output logic        sns_reset_conn,
  output logic [13:0] temp_raw,
  output logic [11:0] rh_raw,
  output logic        temp_vld,
  output logic        rh_vld,
  output logic        upd,
  output logic [7:0]  err_cnt,
  output logic        overrun,
  output logic        busy
);

  localparam int PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RW = (RECOV_CYC > 0) ? $clog2(RECOV_CYC + 1) : 1;
  localparam int YW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RECOV_LEN   = RW'(RECOV_CYC);
  localparam logic [YW-1:0] RETRY_MAX   = YW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_ISSUE, S_WAIT, S_RECOV, S_NEXT, S_HOLD
  } state_t;

  state_t      state_reg, state_next;
  logic        meas_reg, meas_next;          // 0 = temperature, 1 = RH
  logic [YW-1:0] retry_reg, retry_next;
  logic [PW-1:0] period_cnt_reg, period_cnt_next;
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [RW-1:0] recov_cnt_reg, recov_cnt_next;
  logic [13:0] temp_raw_reg, temp_raw_next;
  logic [11:0] rh_raw_reg, rh_raw_next;
  logic        temp_vld_reg, temp_vld_next;
  logic        rh_vld_reg, rh_vld_next;
  logic [7:0]  err_cnt_reg, err_cnt_next;
  logic        overrun_reg, overrun_next;

  logic period_last;
  logic cycle_start;
  logic conv_fail;

  assign period_last = (period_cnt_reg == PERIOD_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      meas_reg       <= 1'b0;
      retry_reg      <= '0;
      period_cnt_reg <= '0;
      tmo_cnt_reg    <= '0;
      recov_cnt_reg  <= '0;
      temp_raw_reg   <= '0;
      rh_raw_reg     <= '0;
      temp_vld_reg   <= 1'b0;
      rh_vld_reg     <= 1'b0;
      err_cnt_reg    <= '0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      meas_reg       <= meas_next;
      retry_reg      <= retry_next;
      period_cnt_reg <= period_cnt_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      recov_cnt_reg  <= recov_cnt_next;
      temp_raw_reg   <= temp_raw_next;
      rh_raw_reg     <= rh_raw_next;
      temp_vld_reg   <= temp_vld_next;
      rh_vld_reg     <= rh_vld_next;
      err_cnt_reg    <= err_cnt_next;
      overrun_reg    <= overrun_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    meas_next       = meas_reg;
    retry_next      = retry_reg;
    period_cnt_next = period_last ? period_cnt_reg : period_cnt_reg + 1'b1;
    tmo_cnt_next    = tmo_cnt_reg;
    recov_cnt_next  = recov_cnt_reg;
    temp_raw_next   = temp_raw_reg;
    rh_raw_next     = rh_raw_reg;
    temp_vld_next   = temp_vld_reg;
    rh_vld_next     = rh_vld_reg;
    err_cnt_next    = err_cnt_reg;
    overrun_next    = overrun_reg;
    cycle_start     = 1'b0;
    conv_fail       = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if ((enable || oneshot) && !sns_busy) begin
          cycle_start = 1'b1;
        end
      end
      S_ARM: begin
        state_next = S_ISSUE;
      end
      S_ISSUE: begin
        tmo_cnt_next = '0;
        state_next   = S_WAIT;
      end
      S_WAIT: begin
        tmo_cnt_next = tmo_cnt_reg + 1'b1;
        // A done on the timeout clock still counts as a completed conversion.
        if (sns_done && !sns_error) begin
          if (!meas_reg) begin
            temp_raw_next = sns_data;
            temp_vld_next = 1'b1;
          end else begin
            rh_raw_next = sns_data[11:0];
            rh_vld_next = 1'b1;
          end
          state_next = S_NEXT;
        end else if (sns_done || (tmo_cnt_reg == TMO_LAST)) begin
          conv_fail = 1'b1;
        end
      end
      S_RECOV: begin
        if (recov_cnt_reg != RECOV_LEN) begin
          recov_cnt_next = recov_cnt_reg + 1'b1;
        end else if (!sns_busy) begin
          state_next = S_ARM;
        end
      end
      S_NEXT: begin
        if (!meas_reg) begin
          meas_next  = 1'b1;
          retry_next = '0;
          state_next = S_ARM;
        end else begin
          // Period already used up before HOLD: flag it, HOLD then exits at once.
          if (period_last) begin
            overrun_next = 1'b1;
          end
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (period_last) begin
          if (enable && !sns_busy) begin
            cycle_start = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (conv_fail) begin
      if (retry_reg < RETRY_MAX) begin
        retry_next     = retry_reg + 1'b1;
        recov_cnt_next = '0;
        state_next     = S_RECOV;
      end else begin
        if (err_cnt_reg != 8'hFF) begin
          err_cnt_next = err_cnt_reg + 1'b1;
        end
        if (!meas_reg) begin
          temp_vld_next = 1'b0;
        end else begin
          rh_vld_next = 1'b0;
        end
        state_next = S_NEXT;
      end
    end

    if (cycle_start) begin
      period_cnt_next = '0;
      meas_next       = 1'b0;
      retry_next      = '0;
      state_next      = S_ARM;
    end
  end

  assign sns_start      = (state_reg == S_ISSUE);
  assign sns_sel        = meas_reg;
  assign sns_reset_conn = (state_reg == S_RECOV) && (recov_cnt_reg != RECOV_LEN);
  assign upd            = (state_reg == S_NEXT) && meas_reg;
  assign busy           = (state_reg != S_IDLE);
  assign temp_raw       = temp_raw_reg;
  assign rh_raw         = rh_raw_reg;
  assign temp_vld       = temp_vld_reg;
  assign rh_vld         = rh_vld_reg;
  assign err_cnt        = err_cnt_reg;
  assign overrun        = overrun_reg;

endmodule

// File: tb/tb_sht10_meas_scheduler.sv
// Bench for sht10_meas_scheduler: behavioural sensor engine, start/result
// scoreboard, a vector table of measurement cycles and hand-written corner cases.
`timescale 1ns/1ps
module tb_sht10_meas_scheduler;

  localparam int P = 4000;
  localparam int T = 1200;
  localparam int R = 40;
  localparam int M = 2;

  logic        clock = 1'b0;
  logic        reset, enable, oneshot;
  logic        sns_busy, sns_done, sns_error;
  logic [13:0] sns_data;
  logic        sns_start, sns_sel, sns_reset_conn;
  logic [13:0] temp_raw;
  logic [11:0] rh_raw;
  logic        temp_vld, rh_vld, upd;
  logic [7:0]  err_cnt;
  logic        overrun, busy;

  always #5 clock = ~clock;

  sht10_meas_scheduler #(
    .PERIOD_CYC(P), .TIMEOUT_CYC(T), .RECOV_CYC(R), .MAX_RETRY(M)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .oneshot(oneshot),
    .sns_busy(sns_busy), .sns_done(sns_done), .sns_error(sns_error),
    .sns_data(sns_data), .sns_start(sns_start), .sns_sel(sns_sel),
    .sns_reset_conn(sns_reset_conn), .temp_raw(temp_raw), .rh_raw(rh_raw),
    .temp_vld(temp_vld), .rh_vld(rh_vld), .upd(upd), .err_cnt(err_cnt),
    .overrun(overrun), .busy(busy)
  );

  typedef struct { int lat; bit err; bit hang; logic [13:0] data; } resp_t;
  typedef struct { logic [13:0] t; logic [11:0] r; bit tv; bit rv; logic [7:0] ec; } res_t;
  typedef struct {
    int t_lat; int t_fail; bit t_hang; logic [13:0] t_data;
    int r_lat; int r_fail; logic [13:0] r_data;
    logic [13:0] e_t; logic [11:0] e_r; bit e_tv; bit e_rv; logic [7:0] e_ec; int e_rc;
  } vec_t;

  resp_t resp_q[$];
  bit    exp_sel_q[$];
  res_t  res_q[$];
  int    start_q[$];
  int    tests_run = 0, tests_failed = 0;
  int    cyc = 0, n_start = 0, n_upd = 0, n_rc = 0, rc_len = 0, upd_cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  // Engine model: answers each start from resp_q, or a quick default reply.
  initial begin : engine
    resp_t cur;
    int    left;
    sns_busy = 1'b0; sns_done = 1'b0; sns_error = 1'b0; sns_data = '0;
    left = 0; cur = '{0, 1'b0, 1'b0, 14'h0};
    forever begin
      @(posedge clock); #1;
      sns_done  = 1'b0;
      sns_error = 1'b0;
      if (reset) begin
        sns_busy = 1'b0;
        left     = 0;
      end else if (sns_start) begin
        if (resp_q.size() > 0) begin
          cur = resp_q.pop_front();
        end else begin
          cur.lat = 50; cur.err = 1'b0; cur.hang = 1'b0;
          cur.data = sns_sel ? 14'h1222 : 14'h0111;
        end
        sns_busy = 1'b1;
        left     = cur.lat;
      end else if (sns_busy) begin
        if (sns_reset_conn) begin
          sns_busy = 1'b0;
        end else if (!cur.hang) begin
          left--;
          if (left <= 0) begin
            sns_done  = 1'b1;
            sns_error = cur.err;
            sns_data  = cur.data;
            sns_busy  = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: pops expected select per start and expected results per upd.
  initial begin : monitor
    res_t e;
    forever begin
      @(posedge clock); #1;
      cyc++;
      if (reset) begin
        rc_len = 0;
      end else begin
        if (sns_start) begin
          n_start++;
          start_q.push_back(cyc);
          check("start_expected", exp_sel_q.size() != 0, 1);
          if (exp_sel_q.size() != 0) check("start_sel", sns_sel, exp_sel_q.pop_front());
        end
        if (sns_reset_conn) begin
          rc_len++;
        end else if (rc_len > 0) begin
          check("reset_conn_len", rc_len, R);
          rc_len = 0;
          n_rc++;
        end
        if (upd) begin
          n_upd++;
          upd_cyc = cyc;
          check("upd_expected", res_q.size() != 0, 1);
          if (res_q.size() != 0) begin
            e = res_q.pop_front();
            check("temp_raw", temp_raw, e.t);
            check("rh_raw", rh_raw, e.r);
            check("temp_vld", temp_vld, e.tv);
            check("rh_vld", rh_vld, e.rv);
            check("err_cnt", err_cnt, e.ec);
          end
        end
      end
    end
  end

  task automatic push_conv(input bit sel, input int nfail, input bit hang,
                           input int lat, input logic [13:0] data);
    int att;
    resp_t r;
    att = (nfail > M) ? M + 1 : nfail + 1;
    for (int k = 0; k < att; k++) begin
      r.lat  = lat;
      r.err  = (k < nfail) && !hang;
      r.hang = (k < nfail) && hang;
      r.data = data;
      resp_q.push_back(r);
      exp_sel_q.push_back(sel);
    end
  endtask

  task automatic wait_upd(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_upd < target && k < budget) begin @(negedge clock); k++; end
    check(name, n_upd >= target, 1);
  endtask

  task automatic wait_start(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_start < target && k < budget) begin @(negedge clock); k++; end
    check(name, n_start >= target, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (busy && k < budget) begin @(negedge clock); k++; end
    check(name, busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start"}, sns_start, 0);
    check({tag, "_sel"}, sns_sel, 0);
    check({tag, "_reset_conn"}, sns_reset_conn, 0);
    check({tag, "_temp_raw"}, temp_raw, 0);
    check({tag, "_rh_raw"}, rh_raw, 0);
    check({tag, "_vld"}, {temp_vld, rh_vld}, 0);
    check({tag, "_upd"}, upd, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  vec_t vecs[5];

  initial begin : test
    int s0, rc0, u0;
    vecs[0] = '{1000, 0, 1'b0, 14'h1A2B, 1000, 0, 14'h05C3, 14'h1A2B, 12'h5C3, 1'b1, 1'b1, 8'd0, 0};
    vecs[1] = '{100,  2, 1'b0, 14'h0123, 100,  0, 14'h3456, 14'h0123, 12'h456, 1'b1, 1'b1, 8'd0, 2};
    vecs[2] = '{100,  3, 1'b1, 14'h0999, 50,   0, 14'h0789, 14'h0123, 12'h789, 1'b0, 1'b1, 8'd1, 2};
    vecs[3] = '{100,  0, 1'b0, 14'h0ABC, 100,  3, 14'h0DEF, 14'h0ABC, 12'h789, 1'b1, 1'b0, 8'd2, 2};
    vecs[4] = '{200,  0, 1'b0, 14'h3FFF, 200,  0, 14'h3FFF, 14'h3FFF, 12'hFFF, 1'b1, 1'b1, 8'd2, 0};

    reset = 1'b1; enable = 1'b0; oneshot = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("reset");

    // Back-to-back periodic cycles with enable held high.
    for (int i = 0; i < 5; i++) begin
      s0 = n_start; rc0 = n_rc; u0 = n_upd;
      push_conv(1'b0, vecs[i].t_fail, vecs[i].t_hang, vecs[i].t_lat, vecs[i].t_data);
      push_conv(1'b1, vecs[i].r_fail, 1'b0, vecs[i].r_lat, vecs[i].r_data);
      res_q.push_back('{vecs[i].e_t, vecs[i].e_r, vecs[i].e_tv, vecs[i].e_rv, vecs[i].e_ec});
      enable = 1'b1;
      wait_upd(u0 + 1, 2 * P, $sformatf("v%0d_upd", i));
      check($sformatf("v%0d_recov_pulses", i), n_rc - rc0, vecs[i].e_rc);
      if (i == 1)
        check("period_gap", (s0 >= 2 && start_q.size() > s0) ? start_q[s0] - start_q[s0-2] : -1, P);
      if (vecs[i].t_hang)
        check("timeout_retry_gap", (start_q.size() > s0 + 1) ? start_q[s0+1] - start_q[s0] : -1, T + R + 3);
    end
    enable = 1'b0;
    wait_idle(2 * P, "vec_idle");
    check("no_overrun", overrun, 0);

    // Overrun: retries stretch the cycle past the period, next cycle starts at once.
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    u0 = n_upd;
    push_conv(1'b0, 2, 1'b0, 1100, 14'h0444);
    push_conv(1'b1, 0, 1'b0, 1100, 14'h0555);
    res_q.push_back('{14'h0444, 12'h555, 1'b1, 1'b1, 8'd0});
    exp_sel_q.push_back(1'b0); exp_sel_q.push_back(1'b1);
    res_q.push_back('{14'h0111, 12'h222, 1'b1, 1'b1, 8'd0});
    enable = 1'b1;
    wait_upd(u0 + 1, 2 * P, "ovr_upd");
    s0 = n_start;
    wait_start(s0 + 1, 20, "ovr_restart");
    check("ovr_restart_gap", start_q[$] - upd_cyc, 3);
    enable = 1'b0;
    check("overrun_set", overrun, 1);
    wait_upd(u0 + 2, 2 * P, "ovr_second_upd");
    wait_idle(2 * P, "ovr_idle");
    check("overrun_sticky", overrun, 1);

    // Oneshot: exactly one cycle; a second pulse mid-cycle is ignored.
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    s0 = n_start; u0 = n_upd;
    exp_sel_q.push_back(1'b0); exp_sel_q.push_back(1'b1);
    res_q.push_back('{14'h0111, 12'h222, 1'b1, 1'b1, 8'd0});
    @(negedge clock); oneshot = 1'b1;
    @(negedge clock); oneshot = 1'b0;
    wait_start(s0 + 1, 20, "os_start");
    oneshot = 1'b1;
    @(negedge clock); oneshot = 1'b0;
    wait_upd(u0 + 1, 2 * P, "os_upd");
    wait_idle(2 * P, "os_idle");
    repeat (50) @(negedge clock);
    check("os_start_count", n_start - s0, 2);
    check("os_upd_count", n_upd - u0, 1);

    // Reset while waiting on a conversion clears everything.
    s0 = n_start;
    push_conv(1'b0, 0, 1'b0, 300, 14'h0777);
    enable = 1'b1;
    wait_start(s0 + 1, 20, "rst_start");
    repeat (50) @(negedge clock);
    check("rst_in_wait_busy", busy, 1);
    reset = 1'b1; enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    resp_q.delete(); exp_sel_q.delete(); res_q.delete();
    check_all_zero("midrst");
    @(negedge clock);
    check("midrst_no_start", n_start - s0, 1);

    // done arriving on the timeout clock is a success.
    u0 = n_upd; rc0 = n_rc;
    push_conv(1'b0, 0, 1'b0, T, 14'h2AAA);
    push_conv(1'b1, 0, 1'b0, 100, 14'h0BBB);
    res_q.push_back('{14'h2AAA, 12'hBBB, 1'b1, 1'b1, 8'd0});
    enable = 1'b1;
    wait_upd(u0 + 1, 2 * P, "coinc_upd");
    enable = 1'b0;
    check("coinc_no_recov", n_rc - rc0, 0);
    wait_idle(2 * P, "final_idle");
    check("queues_drained", exp_sel_q.size() + res_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
